// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle command sequencer for the 8x16 register-file/ALU datapath.
// Accepts one command per cmd_valid/cmd_ready handshake, then steps through
// read A, read B, execute and write-back, driving the datapath control lines.
// Optional feature: define SEQ_TRAP_EN to trap illegal ops. The sticky err stays
// set until reset. When undefined, an illegal op runs as a one-cycle NOP.
// Ports:
//   clk, reset (async, active-high)
//   cmd_valid/cmd_ready handshake; cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm command fields
//   Z_out          datapath status (not used internally)
//   datapath_in, vsel, writenum, readnum, write, loada, loadb, loadc, loads,
//   asel, bsel, shift, ALUop   datapath control
//   busy, done, err            sequencer status
// Every output is registered and decoded from the next state and the next latch contents.
module datapath_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rn,
    input  logic [REG_AW-1:0] cmd_rm,
    input  logic [1:0]        cmd_shift,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic              Z_out,
    output logic [DATA_W-1:0] datapath_in,
    output logic              vsel,
    output logic [REG_AW-1:0] writenum,
    output logic [REG_AW-1:0] readnum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_IMM = 3'd1;
    localparam logic [2:0] S_LD_A   = 3'd2;
    localparam logic [2:0] S_LD_B   = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WR_C   = 3'd5;
    localparam logic [2:0] S_ILL    = 3'd6;   // TRAP with SEQ_TRAP_EN, otherwise NOP

    localparam logic [2:0] OP_MOV_IMM = 3'b000;
    localparam logic [2:0] OP_MOV_REG = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_CMP     = 3'b011;
    localparam logic [2:0] OP_AND     = 3'b100;
    localparam logic [2:0] OP_MVN     = 3'b101;

    logic [2:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
    logic [1:0]        sh_q, sh_d;
    logic [DATA_W-1:0] imm_q, imm_d;

    logic              ready_d, busy_d, done_d, err_d;
    logic              write_d, vsel_d, loada_d, loadb_d, loadc_d, loads_d, asel_d;
    logic [REG_AW-1:0] readnum_d, writenum_d;
    logic [1:0]        shift_d, aluop_d;
    logic [DATA_W-1:0] dpin_d;

    // Status input is only observed by the command source.
    logic unused_z;
    assign unused_z = Z_out;

    // State and command latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            sh_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            sh_q    <= sh_d;
            imm_q   <= imm_d;
        end
    end

    // Next state, latch update and next-output decode.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        sh_d    = sh_q;
        imm_d   = imm_q;

        case (state_q)
            S_IDLE: begin
                // cmd_ready is already low while err is set.
                if (cmd_valid && cmd_ready) begin
                    op_d  = cmd_op;
                    rd_d  = cmd_rd;
                    rn_d  = cmd_rn;
                    rm_d  = cmd_rm;
                    sh_d  = cmd_shift;
                    imm_d = cmd_imm;
                    case (cmd_op)
                        OP_MOV_IMM:              state_d = S_WR_IMM;
                        OP_ADD, OP_AND, OP_CMP:  state_d = S_LD_A;
                        OP_MOV_REG, OP_MVN:      state_d = S_LD_B;
                        default:                 state_d = S_ILL;
                    endcase
                end
            end
            S_LD_A:  state_d = S_LD_B;
            S_LD_B:  state_d = S_EXEC;
            S_EXEC:  state_d = (op_q == OP_CMP) ? S_IDLE : S_WR_C;
            default: state_d = S_IDLE;   // WR_IMM, WR_C, ILL
        endcase

`ifdef SEQ_TRAP_EN
        err_d = err || (state_d == S_ILL);
`else
        err_d = 1'b0;
`endif

        ready_d    = (state_d == S_IDLE) && !err_d;
        busy_d     = (state_d != S_IDLE);
        done_d     = 1'b0;
        write_d    = 1'b0;
        vsel_d     = 1'b0;
        loada_d    = 1'b0;
        loadb_d    = 1'b0;
        loadc_d    = 1'b0;
        loads_d    = 1'b0;
        asel_d     = 1'b0;
        readnum_d  = '0;
        writenum_d = '0;
        shift_d    = '0;
        aluop_d    = '0;
        dpin_d     = '0;

        // Latched fields appear on the datapath in every non-idle state.
        if (state_d != S_IDLE) begin
            readnum_d  = (state_d == S_LD_A) ? rn_d : rm_d;
            writenum_d = rd_d;
            shift_d    = sh_d;
            dpin_d     = imm_d;
            case (op_d)
                OP_CMP:  aluop_d = 2'b01;
                OP_AND:  aluop_d = 2'b10;
                OP_MVN:  aluop_d = 2'b11;
                default: aluop_d = 2'b00;
            endcase
        end

        case (state_d)
            S_WR_IMM: begin
                write_d = 1'b1;
                vsel_d  = 1'b1;
                done_d  = 1'b1;
            end
            S_LD_A: loada_d = 1'b1;
            S_LD_B: loadb_d = 1'b1;
            S_EXEC: begin
                loadc_d = 1'b1;
                loads_d = (op_d == OP_CMP);
                done_d  = (op_d == OP_CMP);
                // A forced to zero so the ALU passes or inverts shifted B.
                asel_d  = (op_d == OP_MOV_REG) || (op_d == OP_MVN);
            end
            S_WR_C: begin
                write_d = 1'b1;
                done_d  = 1'b1;
            end
`ifndef SEQ_TRAP_EN
            S_ILL: done_d = 1'b1;
`endif
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            write       <= 1'b0;
            vsel        <= 1'b0;
            loada       <= 1'b0;
            loadb       <= 1'b0;
            loadc       <= 1'b0;
            loads       <= 1'b0;
            asel        <= 1'b0;
            bsel        <= 1'b0;
            readnum     <= '0;
            writenum    <= '0;
            shift       <= '0;
            ALUop       <= '0;
            datapath_in <= '0;
        end else begin
            cmd_ready   <= ready_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            write       <= write_d;
            vsel        <= vsel_d;
            loada       <= loada_d;
            loadb       <= loadb_d;
            loadc       <= loadc_d;
            loads       <= loads_d;
            asel        <= asel_d;
            bsel        <= 1'b0;
            readnum     <= readnum_d;
            writenum    <= writenum_d;
            shift       <= shift_d;
            ALUop       <= aluop_d;
            datapath_in <= dpin_d;
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Testbench for datapath_sequencer: table-driven per-cycle control checks plus
// hand-written sequences for illegal ops, mid-command reset and command hold-off.
// A small register-file/ALU model is driven by the sequencer outputs.
module tb_datapath_sequencer;

    localparam int OP_IMM = 0, OP_MOVR = 1, OP_ADD = 2, OP_CMP = 3, OP_AND = 4, OP_MVN = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
    logic [1:0]  cmd_shift;
    logic [15:0] cmd_imm;
    logic [15:0] datapath_in;
    logic        vsel, write, loada, loadb, loadc, loads, asel, bsel, busy, done, err;
    logic [2:0]  writenum, readnum;
    logic [1:0]  shift, ALUop;

    // Datapath model
    logic [15:0] rf [8] = '{default: 16'h0};
    logic [15:0] a_q = 16'h0, b_q = 16'h0, c_q = 16'h0;
    logic        z_q = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    datapath_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .cmd_shift(cmd_shift), .cmd_imm(cmd_imm), .Z_out(z_q),
        .datapath_in(datapath_in), .vsel(vsel), .writenum(writenum), .readnum(readnum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] shf(input logic [15:0] b, input logic [1:0] code);
        case (code)
            2'b00:   return b;
            2'b01:   return {b[14:0], 1'b0};
            2'b10:   return {1'b0, b[15:1]};
            default: return {b[15], b[15:1]};
        endcase
    endfunction

    function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (loada) a_q <= rf[readnum];
        if (loadb) b_q <= rf[readnum];
        if (loadc) c_q <= alu(asel ? 16'h0 : a_q, bsel ? 16'h0 : shf(b_q, shift), ALUop);
        if (loads) z_q <= (alu(asel ? 16'h0 : a_q, bsel ? 16'h0 : shf(b_q, shift), ALUop) == 16'h0);
        if (write) rf[writenum] <= vsel ? datapath_in : c_q;
    end

    // Expected control word: {ready,busy,done,err,write,vsel,la,lb,lc,ls,asel,bsel,ALUop,shift,readnum,writenum,datapath_in}
    function automatic logic [37:0] mk(input int rdy, input int bsy, input int dn, input int wr,
                                       input int vs, input int la, input int lb, input int lc,
                                       input int ls, input int as, input int al, input int sh,
                                       input int rdn, input int wrn, input int dp, input int er);
        return {1'(rdy), 1'(bsy), 1'(dn), 1'(er), 1'(wr), 1'(vs), 1'(la), 1'(lb), 1'(lc),
                1'(ls), 1'(as), 1'b0, 2'(al), 2'(sh), 3'(rdn), 3'(wrn), 16'(dp)};
    endfunction

    function automatic logic [37:0] actual();
        return {cmd_ready, busy, done, err, write, vsel, loada, loadb, loadc, loads, asel, bsel,
                ALUop, shift, readnum, writenum, datapath_in};
    endfunction

    typedef struct {
        logic        v;
        logic [2:0]  op, rd, rn, rm;
        logic [1:0]  sh;
        logic [15:0] imm;
        logic [37:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int v, input int op, input int rd, input int rn, input int rm,
                       input int sh, input int imm, input logic [37:0] exp);
        vec_t r;
        r.v = 1'(v); r.op = 3'(op); r.rd = 3'(rd); r.rn = 3'(rn); r.rm = 3'(rm);
        r.sh = 2'(sh); r.imm = 16'(imm); r.exp = exp;
        tbl.push_back(r);
    endtask

    task automatic set_cmd(input int v, input int op, input int rd, input int rn, input int rm,
                           input int sh, input int imm);
        cmd_valid = 1'(v); cmd_op = 3'(op); cmd_rd = 3'(rd); cmd_rn = 3'(rn);
        cmd_rm = 3'(rm); cmd_shift = 2'(sh); cmd_imm = 16'(imm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    logic [37:0] idle_w;

    initial begin
        idle_w = mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        reset = 1'b1;
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("reset_state", actual(), idle_w);
        reset = 1'b0;

        // MOV_IMM R0=7, then R1=2 (second held off by one idle cycle)
        add(0, 0,      0,0,0,0,0, idle_w);
        add(1, OP_IMM, 0,0,0,0,7, mk(0,1,1,1,1,0,0,0,0,0,0,0,0,0,7,0));
        add(1, OP_IMM, 1,0,0,0,2, idle_w);
        add(1, OP_IMM, 1,0,0,0,2, mk(0,1,1,1,1,0,0,0,0,0,0,0,0,1,2,0));
        add(0, 0,      0,0,0,0,0, idle_w);
        // ADD R2 = R1 + (R0<<1)
        add(1, OP_ADD, 2,1,0,1,0, mk(0,1,0,0,0,1,0,0,0,0,0,1,1,2,0,0));
        add(0, 0,      0,0,0,0,0, mk(0,1,0,0,0,0,1,0,0,0,0,1,0,2,0,0));
        add(0, 0,      0,0,0,0,0, mk(0,1,0,0,0,0,0,1,0,0,0,1,0,2,0,0));
        add(0, 0,      0,0,0,0,0, mk(0,1,1,1,0,0,0,0,0,0,0,1,0,2,0,0));
        add(0, 0,      0,0,0,0,0, idle_w);
        // CMP R0, R0
        add(1, OP_CMP, 5,0,0,0,0, mk(0,1,0,0,0,1,0,0,0,0,1,0,0,5,0,0));
        add(0, 0,      0,0,0,0,0, mk(0,1,0,0,0,0,1,0,0,0,1,0,0,5,0,0));
        add(0, 0,      0,0,0,0,0, mk(0,1,1,0,0,0,0,1,1,0,1,0,0,5,0,0));
        add(0, 0,      0,0,0,0,0, idle_w);
        // MVN R3 = ~R1
        add(1, OP_MVN, 3,0,1,0,0, mk(0,1,0,0,0,0,1,0,0,0,3,0,1,3,0,0));
        add(0, 0,      0,0,0,0,0, mk(0,1,0,0,0,0,0,1,0,1,3,0,1,3,0,0));
        add(0, 0,      0,0,0,0,0, mk(0,1,1,1,0,0,0,0,0,0,3,0,1,3,0,0));
        add(0, 0,      0,0,0,0,0, idle_w);
        // AND R4 = R2 & R3
        add(1, OP_AND, 4,2,3,0,0, mk(0,1,0,0,0,1,0,0,0,0,2,0,2,4,0,0));
        add(0, 0,      0,0,0,0,0, mk(0,1,0,0,0,0,1,0,0,0,2,0,3,4,0,0));
        add(0, 0,      0,0,0,0,0, mk(0,1,0,0,0,0,0,1,0,0,2,0,3,4,0,0));
        add(0, 0,      0,0,0,0,0, mk(0,1,1,1,0,0,0,0,0,0,2,0,3,4,0,0));
        add(0, 0,      0,0,0,0,0, idle_w);
        // MOV_REG R6 = R2 >> 1
        add(1, OP_MOVR, 6,0,2,2,0, mk(0,1,0,0,0,0,1,0,0,0,0,2,2,6,0,0));
        add(0, 0,       0,0,0,0,0, mk(0,1,0,0,0,0,0,1,0,1,0,2,2,6,0,0));
        add(0, 0,       0,0,0,0,0, mk(0,1,1,1,0,0,0,0,0,0,0,2,2,6,0,0));
        add(0, 0,       0,0,0,0,0, idle_w);

        for (int i = 0; i < tbl.size(); i++) begin
            cmd_valid = tbl[i].v; cmd_op = tbl[i].op; cmd_rd = tbl[i].rd;
            cmd_rn = tbl[i].rn; cmd_rm = tbl[i].rm; cmd_shift = tbl[i].sh; cmd_imm = tbl[i].imm;
            tick();
            check($sformatf("vec%0d", i), actual(), tbl[i].exp);
        end

        check("R2_add",   38'(rf[2]), 38'(16));
        check("Z_cmp",    38'(z_q),   38'(1));
        check("R5_nowr",  38'(rf[5]), 38'(0));
        check("R3_mvn",   38'(rf[3]), 38'(16'hFFFD));
        check("R4_and",   38'(rf[4]), 38'(16));
        check("R6_movr",  38'(rf[6]), 38'(8));

        // Illegal op 3'b110
        set_cmd(1, 6, 0, 0, 0, 0, 0);
        tick();
`ifdef SEQ_TRAP_EN
        check("trap_state", actual(), mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,1));
        set_cmd(1, OP_IMM, 1, 0, 0, 0, 9);
        tick();
        check("trap_idle", actual(), mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1));
        tick();
        tick();
        check("trap_stuck", actual(), mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1));
`else
        check("nop_state", actual(), mk(0,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("nop_idle", actual(), idle_w);
        check("nop_R1", 38'(rf[1]), 38'(2));
`endif
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2;
        check("reset_clr", actual(), idle_w);
        reset = 1'b0;
        tick();

        // Reset during LD_B of ADD R7 = R1 + R0
        set_cmd(1, OP_ADD, 7, 1, 0, 0, 0);
        tick();
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("rst_ldb", actual(), mk(0,1,0,0,0,0,1,0,0,0,0,0,0,7,0,0));
        reset = 1'b1;
        #2;
        check("rst_async", actual(), idle_w);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rst_R7", 38'(rf[7]), 38'(0));
        set_cmd(1, OP_IMM, 3, 0, 0, 0, 5);
        tick();
        check("rst_movimm", actual(), mk(0,1,1,1,1,0,0,0,0,0,0,0,0,3,5,0));
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("rst_idle", actual(), idle_w);
        check("rst_R3", 38'(rf[3]), 38'(5));

        // MVN R5 = ~R0 with cmd_valid held and fields changing while busy
        set_cmd(1, OP_MVN, 5, 0, 0, 0, 0);
        tick();
        check("hold_ldb", actual(), mk(0,1,0,0,0,0,1,0,0,0,3,0,0,5,0,0));
        set_cmd(1, OP_IMM, 6, 1, 2, 3, 16'h1234);
        tick();
        check("hold_exec", actual(), mk(0,1,0,0,0,0,0,1,0,1,3,0,0,5,0,0));
        tick();
        check("hold_wrc", actual(), mk(0,1,1,1,0,0,0,0,0,0,3,0,0,5,0,0));
        tick();
        check("hold_idle", actual(), idle_w);
        tick();
        check("hold_second", actual(), mk(0,1,1,1,1,0,0,0,0,0,0,3,2,6,16'h1234,0));
        set_cmd(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("hold_R5", 38'(rf[5]), 38'(16'hFFF8));
        check("hold_R6", 38'(rf[6]), 38'(16'h1234));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
